display_queue: RTL and testbench
================================

# display_queue

Buffers 8-bit values that the game logic wants shown and hands them one at a time to the seven-segment display controller directly downstream. A new value is issued only after the controller has finished the previous digit sequence. This lets the game core push a result without waiting on display timing. The block sits between the game core and `sevenseg_display_controller`: its `value`/`trigger` outputs feed that controller, and it consumes the controller's `done`.

## Interface
- `DEPTH`, 4: number of queued entries; power of two, ≥2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `push`  in  1  enqueue request; sampled every cycle.
- `push_value`  in  8  value to enqueue when `push`=1.
- `flush`  in  1  discard all queued (not yet issued) entries.
- `full`  out  1  `level`==DEPTH.
- `level`  out  $clog2(DEPTH+1)  number of queued entries, excluding the one being displayed.
- `busy`  out  1  a value is being displayed (trigger issued, `done` not yet seen).
- `value`  out  8  value presented to the display controller; registered.
- `trigger`  out  1  one-cycle start pulse to the display controller; registered.
- `done`  in  1  one-cycle pulse from the display controller: sequence finished.

## Operation
- Storage: circular FIFO with `DEPTH` entries, a head pointer, a tail pointer, and a `level` counter.
- The FSM has two states:
  - IDLE: if `level`>0, pop the head into `value`, set `trigger`=1 on the next cycle, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: wait for `done`.
    - On `done` with `level`>0, pop and issue the next value immediately. `trigger` is high on the cycle after `done`, and the FSM stays in BUSY.
    - On `done` with `level`=0, go to IDLE.
- `trigger` is high for exactly one cycle per issued value.
- `value` holds its last issued content until the next issue; it never changes while `busy`=1.
- `done` received in IDLE is ignored.
- `busy`=1 exactly while the FSM is in BUSY.
- Push while not full: the entry is written at the tail and `level` increments.
- Push and pop on the same cycle: `level` is unchanged. This also holds when full, because the pop frees a slot and the push is accepted.
- Push while full with no pop on that cycle: behaviour is set by the Configuration section.
- `flush`:
  - Sets `level`=0 and resets both pointers.
  - A `push` on the same cycle as `flush` is discarded.
  - A pop issued on that same cycle takes precedence: its value is issued before the queue is cleared.
  - The value currently displayed is not aborted; the block still waits for its `done`.
- Pointers wrap modulo DEPTH. `level` never exceeds DEPTH and never underflows.

## Timing
- Reset values: `value`=0, `trigger`=0, `busy`=0, `level`=0, `full`=0, FSM in IDLE, both pointers at 0.
- Reset applied mid-display drops the queue and the in-flight value. `done` arriving afterwards is ignored.
- Latency from push to display with the block idle and empty: `push` at cycle N, `level`=1 at N+1, `trigger` and `value` valid at N+2.
- Back-to-back issue: `done` at cycle M, next `trigger` at M+1.
- `full` and `level` are registered and reflect the state after each edge.

## Configuration
- `DISPLAY_QUEUE_DROP_OLDEST_EN`:
  - Defined: a push while full with no pop overwrites the oldest entry. Head and tail both advance, `level` stays at DEPTH, and the newest values are kept.
  - Undefined: a push while full with no pop is rejected. Queue contents are unchanged.

## Structure
- Shared package holds:
  - FSM state encodings: ST_IDLE=1'b0, ST_BUSY=1'b1.
  - Display value width constant VALUE_W=8, also used by the display controller.
- One natural sub-module, `display_fifo`: storage, pointers, `level`, `full`, push/pop/flush and drop-oldest handling.
- The top level holds the FSM and the `value`/`trigger` output registers.

## Test plan
- Reset, then push 8'd42 at cycle 1: `trigger`=1 and `value`=42 at cycle 3, `busy`=1. Pulse `done`: `busy`=0 on the next cycle.
- Push 7, 200, 0 on consecutive cycles: values are issued in order 7, 200, 0. Each `trigger` comes one cycle after the preceding `done`; the last `done` returns the FSM to IDLE.
- DEPTH=4 with the display busy, push 1, 2, 3, 4, 5:
  - Without the macro: `full`=1, 5 is dropped, and the issued sequence is 1, 2, 3, 4.
  - With the macro: the sequence is 2, 3, 4, 5.
- Queue full and `done` arrives on the same cycle as a push of 9: the pop and push both complete, `level` stays 4, and 9 is issued last.
- Flush while busy with 3 entries queued: `level`=0 next cycle, `value` is unchanged, and after `done` the FSM goes to IDLE with no new `trigger`.
- Assert `rst` while busy with 2 queued: all outputs return to their reset values, and a subsequent `done` pulse produces no `trigger`.

Source files
------------

// File: rtl/display_queue_pkg.sv
// rtl/display_queue_pkg.sv - shared state encodings and width constants for the display queue
package display_queue_pkg;

    // Width of one display value; the seven-segment controller uses the same constant.
    localparam int VALUE_W = 8;

    // Issue FSM encodings.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/display_fifo.sv
// rtl/display_fifo.sv - circular value store with level/full tracking, flush and optional drop-oldest (DISPLAY_QUEUE_DROP_OLDEST_EN)
module display_fifo
    import display_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [VALUE_W-1:0]             push_value,
    input  logic                           pop,
    input  logic                           flush,
    output logic [VALUE_W-1:0]             head_value,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [VALUE_W-1:0] mem_q [DEPTH];
    logic [VALUE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               do_pop;
    logic               push_ok;

    // Head entry is read combinationally so the top can capture it on the pop cycle.
    assign head_value = mem_q[head_q];
    assign level      = level_q;
    assign full       = full_q;

    // Next-state for storage, pointers and occupancy; flush wins over push but the
    // popped head has already been read out by the top on the same cycle.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        do_pop  = pop && (level_q != '0);
        // A pop on the same cycle frees a slot, so a push into a full queue still lands.
        push_ok = push && (!full_q || do_pop);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
            if (push_ok) begin
                mem_d[tail_q] = push_value;
                tail_d        = tail_q + 1'b1;
            end
`ifdef DISPLAY_QUEUE_DROP_OLDEST_EN
            // Full with no pop: overwrite the oldest entry and slide the window forward.
            if (push && full_q && !do_pop) begin
                mem_d[tail_q] = push_value;
                tail_d        = tail_q + 1'b1;
                head_d        = head_q + 1'b1;
            end
`endif
            case ({push_ok, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        full_d = (level_d == LVL_W'(DEPTH));
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            full_q  <= full_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/display_queue.sv
// rtl/display_queue.sv - queues values for the seven-segment controller and issues one per done (DISPLAY_QUEUE_DROP_OLDEST_EN selects drop-oldest on overflow)
module display_queue
    import display_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [7:0]                     push_value,
    input  logic                           flush,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           busy,
    output logic [7:0]                     value,
    output logic                           trigger,
    input  logic                           done
);

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               trigger_q, trigger_d;
    logic               pop;
    logic [VALUE_W-1:0] head_value;

    display_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_value (push_value),
        .pop        (pop),
        .flush      (flush),
        .head_value (head_value),
        .level      (level),
        .full       (full)
    );

    assign busy    = (state_q == ST_BUSY);
    assign value   = value_q;
    assign trigger = trigger_q;

    // Issue decision: pop the head when idle, or right on done while busy, so the
    // next trigger follows done by one cycle; done while idle is ignored.
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        trigger_d = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    value_d   = head_value;
                    trigger_d = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    if (level != '0) begin
                        pop       = 1'b1;
                        value_d   = head_value;
                        trigger_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered controller outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            trigger_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            trigger_q <= trigger_d;
        end
    end

endmodule

// File: tb/tb_display_queue.sv
// tb/tb_display_queue.sv - directed self-checking bench for display_queue
module tb_display_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_value = 8'd0;
    logic       flush = 1'b0;
    logic       done = 1'b0;
    logic       full;
    logic [2:0] level;
    logic       busy;
    logic [7:0] value;
    logic       trigger;

    int n_cmp = 0;
    int n_err = 0;

    display_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_value (push_value),
        .flush      (flush),
        .full       (full),
        .level      (level),
        .busy       (busy),
        .value      (value),
        .trigger    (trigger),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_step(input logic [7:0] v);
        push = 1'b1;
        push_value = v;
        step();
        push = 1'b0;
    endtask

    task automatic done_issue(input string tag, input logic [7:0] exp);
        done = 1'b1;
        step();
        done = 1'b0;
        check({tag, "_trig"}, trigger, 1);
        check({tag, "_val"}, value, exp);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic done_idle(input string tag);
        done = 1'b1;
        step();
        done = 1'b0;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_trig"}, trigger, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_value"}, value, 0);
        check({tag, "_trig"}, trigger, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_full"}, full, 0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        check_reset("rst");

        // Single push: level at N+1, trigger/value at N+2
        push_step(8'd42);
        check("lat_level", level, 1);
        check("lat_trig_early", trigger, 0);
        step();
        check("lat_trig", trigger, 1);
        check("lat_val", value, 42);
        check("lat_busy", busy, 1);
        check("lat_level0", level, 0);
        step();
        check("lat_trig_pulse", trigger, 0);
        done_idle("lat_done");

        // In-order issue 7, 200, 0
        push_step(8'd7);
        push_step(8'd200);
        check("ord_first_trig", trigger, 1);
        check("ord_first_val", value, 7);
        check("ord_level1", level, 1);
        push_step(8'd0);
        check("ord_level2", level, 2);
        check("ord_trig_low", trigger, 0);
        check("ord_val_hold", value, 7);
        done_issue("ord_200", 8'd200);
        done_issue("ord_0", 8'd0);
        done_idle("ord_end");

        // Overflow while busy
        push_step(8'd100);
        push_step(8'd1);
        check("ovf_show", value, 100);
        push_step(8'd2);
        push_step(8'd3);
        push_step(8'd4);
        check("ovf_full4", full, 1);
        push_step(8'd5);
        check("ovf_full5", full, 1);
        check("ovf_level5", level, 4);
`ifdef DISPLAY_QUEUE_DROP_OLDEST_EN
        done_issue("ovf_a", 8'd2);
        done_issue("ovf_b", 8'd3);
        done_issue("ovf_c", 8'd4);
        done_issue("ovf_d", 8'd5);
`else
        done_issue("ovf_a", 8'd1);
        done_issue("ovf_b", 8'd2);
        done_issue("ovf_c", 8'd3);
        done_issue("ovf_d", 8'd4);
`endif
        check("ovf_empty", level, 0);
        done_idle("ovf_end");

        // Full queue, done and push of 9 on the same cycle
        push_step(8'd100);
        push_step(8'd1);
        push_step(8'd2);
        push_step(8'd3);
        push_step(8'd4);
        check("pp_full", full, 1);
        push = 1'b1;
        push_value = 8'd9;
        done = 1'b1;
        step();
        push = 1'b0;
        done = 1'b0;
        check("pp_level", level, 4);
        check("pp_full_hold", full, 1);
        check("pp_trig", trigger, 1);
        check("pp_val", value, 1);
        done_issue("pp_2", 8'd2);
        done_issue("pp_3", 8'd3);
        done_issue("pp_4", 8'd4);
        done_issue("pp_9", 8'd9);
        done_idle("pp_end");

        // Flush while busy with 3 queued, with a push on the same cycle
        push_step(8'd100);
        push_step(8'd1);
        push_step(8'd2);
        push_step(8'd3);
        check("fl_level3", level, 3);
        flush = 1'b1;
        push = 1'b1;
        push_value = 8'd77;
        step();
        flush = 1'b0;
        push = 1'b0;
        check("fl_level0", level, 0);
        check("fl_val", value, 100);
        check("fl_busy", busy, 1);
        check("fl_trig", trigger, 0);
        done_idle("fl_done");
        step();
        check("fl_no_trig", trigger, 0);

        // Flush on the same cycle as a done-driven pop: the head is still issued
        push_step(8'd100);
        push_step(8'd11);
        push_step(8'd12);
        check("flp_level2", level, 2);
        flush = 1'b1;
        done = 1'b1;
        step();
        flush = 1'b0;
        done = 1'b0;
        check("flp_trig", trigger, 1);
        check("flp_val", value, 11);
        check("flp_level", level, 0);
        done_idle("flp_end");

        // Reset mid-display with 2 queued
        push_step(8'd100);
        push_step(8'd21);
        push_step(8'd22);
        check("rs_level2", level, 2);
        check("rs_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("rs");
        done = 1'b1;
        step();
        done = 1'b0;
        check("rs_done_trig", trigger, 0);
        check("rs_done_busy", busy, 0);
        step();
        check("rs_after_trig", trigger, 0);
        check("rs_after_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
